// File: rtl/senone_scheduler.sv
// Senone scoring scheduler: issues one score request per senone,
// forwards returned scores in order and tracks the frame maximum.
module senone_scheduler #(
    parameter int N_SENONES = 1024,
    parameter int MAX_OUT   = 4,
    parameter int ADDR_W    = $clog2(N_SENONES)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     vector_valid,
    output logic                     vector_ready,
    output logic                     score_req,
    output logic [ADDR_W-1:0]        senone_addr,
    input  logic                     score_ack,
    input  logic                     score_valid,
    input  logic signed [15:0]       score_in,
    output logic                     new_vector_available,
    output logic                     new_senone,
    output logic                     last_senone,
    output logic signed [15:0]       current_score,
    output logic signed [15:0]       best_score,
    output logic [ADDR_W-1:0]        best_senone,
    output logic                     frame_done,
    output logic                     overrun
);
    localparam int CW = ADDR_W + 1;
    localparam logic [CW-1:0] N_TOT  = CW'(N_SENONES);
    localparam logic [CW-1:0] N_LAST = CW'(N_SENONES - 1);
    localparam logic [CW-1:0] ONE    = CW'(1);
    localparam logic [3:0]    OUT_MX = 4'(MAX_OUT);

    typedef enum logic [2:0] {
        IDLE, CLEAR, ISSUE, DRAIN, DONE
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0] issued;
    logic [CW-1:0] returned;
    logic [3:0]    outstanding;
    logic          xfer;
    logic          accept;
    logic          start;
    logic          done_nxt;

    assign xfer        = score_req & score_ack;
    assign accept      = score_valid & (outstanding != 4'd0);
    assign start       = (state == IDLE) & vector_valid;
    assign done_nxt    = accept & (returned == N_LAST);
    assign senone_addr = issued[ADDR_W-1:0];

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and per-state control outputs
    always_comb begin
        state_nxt            = state;
        vector_ready         = 1'b0;
        new_vector_available = 1'b0;
        score_req            = 1'b0;
        frame_done           = 1'b0;
        unique case (state)
            IDLE: begin
                vector_ready = 1'b1;
                if (vector_valid) state_nxt = CLEAR;
            end
            CLEAR: begin
                new_vector_available = 1'b1;
                state_nxt            = ISSUE;
            end
            ISSUE: begin
                score_req = (issued < N_TOT) &&
                            (outstanding < OUT_MX);
                if (issued == N_TOT)
                    state_nxt = done_nxt ? DONE : DRAIN;
            end
            DRAIN: begin
                if (done_nxt) state_nxt = DONE;
            end
            DONE: begin
                frame_done = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Issue, return and in-flight counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            issued      <= '0;
            returned    <= '0;
            outstanding <= '0;
        end else if (start) begin
            issued      <= '0;
            returned    <= '0;
            outstanding <= '0;
        end else begin
            if (xfer)   issued   <= issued + ONE;
            if (accept) returned <= returned + ONE;
            if (xfer && !accept)
                outstanding <= outstanding + 4'd1;
            else if (!xfer && accept)
                outstanding <= outstanding - 4'd1;
        end
    end

    // Score forwarding, running maximum and overrun flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            new_senone    <= 1'b0;
            last_senone   <= 1'b0;
            current_score <= '0;
            best_score    <= 16'sh8000;
            best_senone   <= '0;
            overrun       <= 1'b0;
        end else begin
            new_senone  <= accept;
            last_senone <= done_nxt;
            if (accept) current_score <= score_in;
            if (start) begin
                best_score  <= 16'sh8000;
                best_senone <= '0;
            end else if (accept && (score_in > best_score)) begin
                best_score  <= score_in;
                best_senone <= returned[ADDR_W-1:0];
            end
            if (start)
                overrun <= 1'b0;
            else if (vector_valid && (state != IDLE))
                overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_senone_scheduler.sv
// Bench for senone_scheduler: scoring-unit model, pulse monitor
// and per-scenario checks against a frame-level reference.
module tb_senone_scheduler;
    localparam int N   = 4;
    localparam int MO  = 2;
    localparam int AW  = $clog2(N);
    localparam int BIG = 1 << 30;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 vector_valid;
    logic                 vector_ready;
    logic                 score_req;
    logic [AW-1:0]        senone_addr;
    logic                 score_ack;
    logic                 score_valid;
    logic signed [15:0]   score_in;
    logic                 new_vector_available;
    logic                 new_senone;
    logic                 last_senone;
    logic signed [15:0]   current_score;
    logic signed [15:0]   best_score;
    logic [AW-1:0]        best_senone;
    logic                 frame_done;
    logic                 overrun;

    int checks = 0;
    int errors = 0;

    int ack_mode   = 0;
    int ret_rand   = 0;
    int ret_budget = BIG;
    bit manual     = 1'b0;
    logic               m_valid = 1'b0;
    logic signed [15:0] m_score = '0;

    logic signed [15:0] scores [N];
    int                 pend[$];
    int                 addr_log[$];
    logic signed [15:0] got_score[$];
    bit                 got_last[$];
    int                 n_done = 0;
    int                 n_nva  = 0;

    senone_scheduler #(
        .N_SENONES(N),
        .MAX_OUT(MO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .vector_valid(vector_valid),
        .vector_ready(vector_ready),
        .score_req(score_req),
        .senone_addr(senone_addr),
        .score_ack(score_ack),
        .score_valid(score_valid),
        .score_in(score_in),
        .new_vector_available(new_vector_available),
        .new_senone(new_senone),
        .last_senone(last_senone),
        .current_score(current_score),
        .best_score(best_score),
        .best_senone(best_senone),
        .frame_done(frame_done),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Scoring unit: in-order returns of accepted requests.
    always @(negedge clk) begin
        score_valid = 1'b0;
        score_ack   = 1'b0;
        score_in    = '0;
        if (!reset) begin
            pend.delete();
        end else if (manual) begin
            score_valid = m_valid;
            score_in    = m_score;
        end else begin
            if (pend.size() > 0 && ret_budget > 0 &&
                (ret_rand == 0 || $urandom_range(0, 1) == 1)) begin
                ret_budget--;
                score_valid = 1'b1;
                score_in    = scores[pend.pop_front()];
            end
            case (ack_mode)
                0:       score_ack = 1'b1;
                1:       score_ack = 1'($urandom_range(0, 1));
                default: score_ack = 1'b0;
            endcase
            if (score_ack && score_req) begin
                pend.push_back(int'(senone_addr));
                addr_log.push_back(int'(senone_addr));
            end
        end
    end

    // Output monitor
    always @(negedge clk) begin
        if (reset) begin
            if (new_senone) begin
                got_score.push_back(current_score);
                got_last.push_back(last_senone);
            end
            if (frame_done) n_done++;
            if (new_vector_available) n_nva++;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_logs();
        addr_log.delete();
        got_score.delete();
        got_last.delete();
        n_done = 0;
        n_nva  = 0;
    endtask

    task automatic start_frame();
        vector_valid = 1'b1;
        tick();
        vector_valid = 1'b0;
    endtask

    task automatic wait_done(input int maxc);
        for (int i = 0; i < maxc; i++) begin
            if (n_done != 0) break;
            tick();
        end
        tick();
    endtask

    task automatic rand_scores();
        for (int i = 0; i < N; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r == 0)      scores[i] = 16'sh8000;
            else if (r == 1) scores[i] = 16'sh7fff;
            else if (r < 4)  scores[i] = scores[0];
            else             scores[i] = 16'($urandom);
        end
    endtask

    // Frame maximum: first index holding the largest value above
    // the most negative score; index 0 if nothing exceeds it.
    function automatic void ref_best(
        output logic signed [15:0] b,
        output int                 idx
    );
        b   = 16'sh8000;
        idx = 0;
        for (int i = 0; i < N; i++)
            if (scores[i] > b) begin
                b   = scores[i];
                idx = i;
            end
    endfunction

    task automatic test_reset();
        reset        = 1'b0;
        vector_valid = 1'b0;
        repeat (3) tick();
        checks++;
        if (vector_ready !== 1'b1 || score_req !== 1'b0 ||
            frame_done !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got rdy=%b req=%b done=%b ovr=%b required 1 0 0 0",
                     vector_ready, score_req, frame_done, overrun);
        end
        checks++;
        if (best_score !== 16'sh8000 || best_senone !== '0 ||
            current_score !== '0 || new_senone !== 1'b0) begin
            errors++;
            $display("FAIL reset_data: got best=%h idx=%0d cur=%h ns=%b required 8000 0 0000 0",
                     best_score, best_senone, current_score, new_senone);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (vector_ready !== 1'b1 || new_vector_available !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got rdy=%b nva=%b required 1 0",
                     vector_ready, new_vector_available);
        end
    endtask

    task automatic test_basic();
        logic signed [15:0] eb;
        int                 ei;
        scores[0] = 16'sd5;
        scores[1] = -16'sd3;
        scores[2] = 16'sd12;
        scores[3] = 16'sd12;
        ack_mode = 0; ret_rand = 0; ret_budget = BIG;
        clear_logs();
        start_frame();
        wait_done(200);
        ref_best(eb, ei);
        checks++;
        if (got_score.size() != N) begin
            errors++;
            $display("FAIL basic_count: got %0d scores required %0d",
                     got_score.size(), N);
        end
        for (int i = 0; i < got_score.size() && i < N; i++) begin
            checks++;
            if (got_score[i] !== scores[i] || got_last[i] != (i == N - 1)) begin
                errors++;
                $display("FAIL basic_score[%0d]: got %0d last=%b required %0d last=%b",
                         i, got_score[i], got_last[i], scores[i], i == N - 1);
            end
        end
        checks++;
        if (n_done != 1 || n_nva != 1) begin
            errors++;
            $display("FAIL basic_pulses: got done=%0d nva=%0d required 1 1",
                     n_done, n_nva);
        end
        checks++;
        if (best_score !== eb || best_senone !== AW'(ei)) begin
            errors++;
            $display("FAIL basic_best: got %0d@%0d required %0d@%0d",
                     best_score, best_senone, eb, ei);
        end
        checks++;
        if (addr_log.size() != N || addr_log[0] != 0 || addr_log[1] != 1 ||
            addr_log[2] != 2 || addr_log[3] != 3) begin
            errors++;
            $display("FAIL basic_addr: got %0d requests required 0,1,2,3",
                     addr_log.size());
        end
    endtask

    task automatic test_backpressure();
        rand_scores();
        ack_mode = 0; ret_rand = 0; ret_budget = 0;
        clear_logs();
        start_frame();
        repeat (8) tick();
        checks++;
        if (addr_log.size() != MO || score_req !== 1'b0) begin
            errors++;
            $display("FAIL bp_limit: got %0d acks req=%b required %0d acks req=0",
                     addr_log.size(), score_req, MO);
        end
        ret_budget = 1;
        tick();
        checks++;
        if (score_valid !== 1'b1 || score_req !== 1'b0) begin
            errors++;
            $display("FAIL bp_return_cycle: got valid=%b req=%b required 1 0",
                     score_valid, score_req);
        end
        tick();
        checks++;
        if (score_req !== 1'b1 || senone_addr !== AW'(2)) begin
            errors++;
            $display("FAIL bp_resume: got req=%b addr=%0d required 1 2",
                     score_req, senone_addr);
        end
        ret_budget = BIG;
        wait_done(200);
        checks++;
        if (addr_log.size() != N || addr_log[0] != 0 || addr_log[1] != 1 ||
            addr_log[2] != 2 || addr_log[3] != 3 ||
            got_score.size() != N || n_done != 1) begin
            errors++;
            $display("FAIL bp_frame: got reqs=%0d scores=%0d done=%0d required %0d %0d 1",
                     addr_log.size(), got_score.size(), n_done, N, N);
        end
    endtask

    task automatic test_ack_stall();
        logic signed [15:0] eb;
        int                 ei;
        rand_scores();
        ack_mode = 2; ret_rand = 0; ret_budget = BIG;
        clear_logs();
        start_frame();
        checks++;
        if (score_req !== 1'b0 || new_vector_available !== 1'b1) begin
            errors++;
            $display("FAIL clear_cycle: got req=%b nva=%b required 0 1",
                     score_req, new_vector_available);
        end
        tick();
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (score_req !== 1'b1 || senone_addr !== '0 ||
                addr_log.size() != 0) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got req=%b addr=%0d acks=%0d required 1 0 0",
                         i, score_req, senone_addr, addr_log.size());
            end
            tick();
        end
        ack_mode = 0;
        wait_done(200);
        ref_best(eb, ei);
        checks++;
        if (got_score.size() != N || best_score !== eb ||
            best_senone !== AW'(ei)) begin
            errors++;
            $display("FAIL stall_frame: got n=%0d best=%0d@%0d required n=%0d %0d@%0d",
                     got_score.size(), best_score, best_senone, N, eb, ei);
        end
    endtask

    task automatic test_min_scores();
        for (int i = 0; i < N; i++) scores[i] = 16'sh8000;
        ack_mode = 1; ret_rand = 1; ret_budget = BIG;
        clear_logs();
        start_frame();
        wait_done(400);
        checks++;
        if (best_score !== 16'sh8000 || best_senone !== '0 ||
            n_done != 1 || got_score.size() != N) begin
            errors++;
            $display("FAIL min_scores: got best=%h idx=%0d done=%0d n=%0d required 8000 0 1 %0d",
                     best_score, best_senone, n_done, got_score.size(), N);
        end
    endtask

    task automatic test_overrun();
        rand_scores();
        ack_mode = 0; ret_rand = 0; ret_budget = 0;
        clear_logs();
        start_frame();
        for (int i = 0; i < 50 && addr_log.size() < MO; i++) tick();
        ret_budget = 2;
        for (int i = 0; i < 50 && addr_log.size() < N; i++) tick();
        repeat (3) tick();
        vector_valid = 1'b1;
        tick();
        vector_valid = 1'b0;
        checks++;
        if (overrun !== 1'b1 || vector_ready !== 1'b0) begin
            errors++;
            $display("FAIL overrun_set: got ovr=%b rdy=%b required 1 0",
                     overrun, vector_ready);
        end
        ret_budget = BIG;
        wait_done(200);
        checks++;
        if (got_score.size() != N || n_done != 1 || n_nva != 1 ||
            overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_frame: got n=%0d done=%0d nva=%0d ovr=%b required %0d 1 1 1",
                     got_score.size(), n_done, n_nva, overrun, N);
        end
        for (int i = 0; i < got_score.size() && i < N; i++) begin
            checks++;
            if (got_score[i] !== scores[i]) begin
                errors++;
                $display("FAIL overrun_score[%0d]: got %0d required %0d",
                         i, got_score[i], scores[i]);
            end
        end
        clear_logs();
        start_frame();
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun_clear: got %b required 0", overrun);
        end
        wait_done(200);
    endtask

    task automatic test_reset_midframe();
        rand_scores();
        ack_mode = 0; ret_rand = 0; ret_budget = 2;
        clear_logs();
        start_frame();
        for (int i = 0; i < 50 && got_score.size() < 2; i++) tick();
        reset = 1'b0;
        #1;
        checks++;
        if (vector_ready !== 1'b1 || score_req !== 1'b0 ||
            new_senone !== 1'b0 || last_senone !== 1'b0 ||
            new_vector_available !== 1'b0 || frame_done !== 1'b0 ||
            overrun !== 1'b0) begin
            errors++;
            $display("FAIL midreset_ctrl: got rdy=%b req=%b ns=%b ls=%b nva=%b fd=%b ovr=%b required 1 0 0 0 0 0 0",
                     vector_ready, score_req, new_senone, last_senone,
                     new_vector_available, frame_done, overrun);
        end
        checks++;
        if (current_score !== '0 || best_score !== 16'sh8000 ||
            best_senone !== '0) begin
            errors++;
            $display("FAIL midreset_data: got cur=%h best=%h idx=%0d required 0000 8000 0",
                     current_score, best_score, best_senone);
        end
        repeat (2) tick();
        reset = 1'b1;
        clear_logs();
        manual  = 1'b1;
        m_valid = 1'b1;
        m_score = 16'sd77;
        tick();
        m_valid = 1'b0;
        repeat (3) tick();
        manual = 1'b0;
        ret_budget = BIG;
        checks++;
        if (got_score.size() != 0 || current_score !== '0 ||
            vector_ready !== 1'b1) begin
            errors++;
            $display("FAIL stray_score: got pulses=%0d cur=%0d rdy=%b required 0 0 1",
                     got_score.size(), current_score, vector_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic signed [15:0] eb;
        int                 ei;
        ack_mode = 1; ret_rand = 1; ret_budget = BIG;
        for (int f = 0; f < 10; f++) begin
            rand_scores();
            clear_logs();
            start_frame();
            wait_done(400);
            ref_best(eb, ei);
            checks++;
            if (got_score.size() != N || n_done != 1 || n_nva != 1) begin
                errors++;
                $display("FAIL b2b_pulses[%0d]: got n=%0d done=%0d nva=%0d required %0d 1 1",
                         f, got_score.size(), n_done, n_nva, N);
            end
            for (int i = 0; i < got_score.size() && i < N; i++) begin
                checks++;
                if (got_score[i] !== scores[i] ||
                    got_last[i] != (i == N - 1) || addr_log[i] != i) begin
                    errors++;
                    $display("FAIL b2b_score[%0d.%0d]: got %0d last=%b addr=%0d required %0d last=%b addr=%0d",
                             f, i, got_score[i], got_last[i], addr_log[i],
                             scores[i], i == N - 1, i);
                end
            end
            checks++;
            if (best_score !== eb || best_senone !== AW'(ei) ||
                overrun !== 1'b0) begin
                errors++;
                $display("FAIL b2b_best[%0d]: got %0d@%0d ovr=%b required %0d@%0d ovr=0",
                         f, best_score, best_senone, overrun, eb, ei);
            end
        end
    endtask

    initial begin
        vector_valid = 1'b0;
        reset        = 1'b0;
        for (int i = 0; i < N; i++) scores[i] = '0;
        test_reset();
        test_basic();
        test_backpressure();
        test_ack_stall();
        test_min_scores();
        test_overrun();
        test_reset_midframe();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
